// File: rtl/rect_port_arbiter_if.sv
// Bus bundle between the feature-evaluation requesters, the rect port arbiter and one rect ROM port.
// The arbiter takes the slave view; the environment (requesters plus ROM) takes the master view.
interface rect_port_arbiter_if #(
  parameter int W_DATA = 5,
  parameter int W_ADDR = 14,
  parameter int N_REQ  = 3
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*W_ADDR-1:0] req_addr;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [W_DATA-1:0]       rsp_data;
  logic                    addr1_valid;
  logic                    addr1_ready;
  logic [W_ADDR-1:0]       addr1_data;
  logic                    data1_valid;
  logic                    data1_ready;
  logic [W_DATA-1:0]       data1;

  modport slave (
    input  req_valid, req_addr, rsp_ready, addr1_ready, data1_valid, data1,
    output req_ready, rsp_valid, rsp_data, addr1_valid, addr1_data, data1_ready
  );

  modport master (
    output req_valid, req_addr, rsp_ready, addr1_ready, data1_valid, data1,
    input  req_ready, rsp_valid, rsp_data, addr1_valid, addr1_data, data1_ready
  );
endinterface

// File: rtl/rect_port_arbiter.sv
// Round-robin sharing of one rect ROM read port with an in-order tag FIFO for response routing.
// Optional orphan-response detection is built when RECT_ARB_CHECK_EN is defined.
module rect_port_arbiter #(
  parameter int W_DATA  = 5,
  parameter int W_ADDR  = 14,
  parameter int N_REQ   = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  rect_port_arbiter_if.slave  bus,
  output logic                err_orphan
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  tag_mem_q [MAX_OUT];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q, count_d;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]  gnt_idx, idx, head;
  logic           found, not_full, not_empty, push, pop;

  assign not_full  = count_q < (PW+1)'(MAX_OUT);
  assign not_empty = count_q != '0;
  assign head      = tag_mem_q[rd_ptr_q];

  // Search starts just after the last accepted winner; addr1_ready is deliberately not an input here.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (not_full) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = IW'((int'(last_q) + k) % N_REQ);
        if (!found && bus.req_valid[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = idx;
        end
      end
    end
  end

  always_comb begin
    bus.addr1_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) bus.addr1_data = bus.req_addr[i*W_ADDR +: W_ADDR];
    end
  end

  assign bus.addr1_valid = |gnt;
  assign bus.req_ready   = gnt & {N_REQ{bus.addr1_ready}};
  assign push            = bus.addr1_valid & bus.addr1_ready;

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.rsp_valid[i] = not_empty & bus.data1_valid & (head == IW'(i));
    end
  end

  // With nothing outstanding the port is drained so a stray word can never wedge it.
  assign bus.data1_ready = not_empty ? bus.rsp_ready[head] : 1'b1;
  assign bus.rsp_data    = bus.data1;
  assign pop             = not_empty & bus.data1_valid & bus.rsp_ready[head];

  always_comb begin
    last_d  = push ? gnt_idx : last_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= IW'(N_REQ - 1);
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      last_q  <= last_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

`ifdef RECT_ARB_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q | (bus.data1_valid & ~not_empty);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_orphan = err_q;
`else
  assign err_orphan = 1'b0;
`endif
endmodule

// File: tb/tb_rect_port_arbiter.sv
// Directed self-checking bench for rect_port_arbiter; expectations follow the RECT_ARB_CHECK_EN setting.
module tb_rect_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic errOrphan;
  int   checks = 0;
  int   errors = 0;
  logic [13:0] addrTab [3];

  rect_port_arbiter_if #(.W_DATA(5), .W_ADDR(14), .N_REQ(3)) bus ();

  rect_port_arbiter #(.W_DATA(5), .W_ADDR(14), .N_REQ(3), .MAX_OUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_orphan (errOrphan)
  );

  always #5 clk = ~clk;

  task automatic setInputs(input logic [2:0] rv, input logic aRdy, input logic dv,
                           input logic [4:0] d, input logic [2:0] rr);
    bus.req_valid   = rv;
    bus.addr1_ready = aRdy;
    bus.data1_valid = dv;
    bus.data1       = d;
    bus.rsp_ready   = rr;
  endtask

  task automatic doReset();
    @(negedge clk);
    setInputs(3'b000, 1'b0, 1'b0, 5'h00, 3'b000);
    bus.req_addr = {addrTab[2], addrTab[1], addrTab[0]};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #2;
    checks++; if (bus.addr1_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr1_valid got %b exp 0", bus.addr1_valid); end
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 000", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 000", bus.req_ready); end
    checks++; if (errOrphan !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_orphan got %b exp 0", errOrphan); end
    checks++; if (bus.data1_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_drain got %b exp 1", bus.data1_ready); end
  endtask

  // Six consecutive accepts with one response popping per cycle so the FIFO never fills.
  task automatic test_round_robin();
    logic [2:0] expGnt, expRsp;
    doReset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      setInputs(3'b111, 1'b1, (k != 0), 5'(k), 3'b111);
      #2;
      expGnt = 3'b001 << (k % 3);
      expRsp = (k == 0) ? 3'b000 : (3'b001 << ((k + 2) % 3));
      checks++; if (bus.req_ready !== expGnt) begin errors++; $display("[TB] FAIL rr_grant cyc %0d got %b exp %b", k, bus.req_ready, expGnt); end
      checks++; if (bus.addr1_data !== addrTab[k % 3]) begin errors++; $display("[TB] FAIL rr_addr cyc %0d got %h exp %h", k, bus.addr1_data, addrTab[k % 3]); end
      checks++; if (bus.rsp_valid !== expRsp) begin errors++; $display("[TB] FAIL rr_rsp cyc %0d got %b exp %b", k, bus.rsp_valid, expRsp); end
    end
  endtask

  task automatic test_routing();
    doReset();
    bus.req_addr = {14'h0020, 14'h0010, 14'h0000};
    @(negedge clk);
    setInputs(3'b010, 1'b1, 1'b0, 5'h00, 3'b111);
    #2;
    checks++; if (bus.addr1_data !== 14'h0010) begin errors++; $display("[TB] FAIL route_addr1 got %h exp 0010", bus.addr1_data); end
    @(negedge clk);
    setInputs(3'b100, 1'b1, 1'b0, 5'h00, 3'b111);
    #2;
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("[TB] FAIL route_grant2 got %b exp 100", bus.req_ready); end
    checks++; if (bus.addr1_data !== 14'h0020) begin errors++; $display("[TB] FAIL route_addr2 got %h exp 0020", bus.addr1_data); end
    @(negedge clk);
    setInputs(3'b000, 1'b1, 1'b1, 5'h05, 3'b111);
    #2;
    checks++; if (bus.rsp_valid !== 3'b010) begin errors++; $display("[TB] FAIL route_rsp1 got %b exp 010", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 5'h05) begin errors++; $display("[TB] FAIL route_data1 got %h exp 05", bus.rsp_data); end
    @(negedge clk);
    setInputs(3'b000, 1'b1, 1'b1, 5'h0A, 3'b111);
    #2;
    checks++; if (bus.rsp_valid !== 3'b100) begin errors++; $display("[TB] FAIL route_rsp2 got %b exp 100", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 5'h0A) begin errors++; $display("[TB] FAIL route_data2 got %h exp 0A", bus.rsp_data); end
    @(negedge clk);
    setInputs(3'b000, 1'b1, 1'b0, 5'h00, 3'b111);
    bus.req_addr = {addrTab[2], addrTab[1], addrTab[0]};
  endtask

  task automatic test_full();
    doReset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      setInputs(3'b001, 1'b1, 1'b0, 5'h00, 3'b111);
      #2;
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL full_accept %0d got %b exp 001", k, bus.req_ready); end
    end
    @(negedge clk);
    #2;
    checks++; if (bus.addr1_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_block got %b exp 0", bus.addr1_valid); end
    @(negedge clk);
    setInputs(3'b001, 1'b1, 1'b1, 5'h11, 3'b111);
    #2;
    checks++; if (bus.addr1_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_no_bypass got %b exp 0", bus.addr1_valid); end
    checks++; if (bus.rsp_valid !== 3'b001) begin errors++; $display("[TB] FAIL full_pop_rsp got %b exp 001", bus.rsp_valid); end
    @(negedge clk);
    setInputs(3'b001, 1'b1, 1'b0, 5'h00, 3'b111);
    #2;
    checks++; if (bus.addr1_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_resume got %b exp 1", bus.addr1_valid); end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      setInputs(3'b111, 1'b0, 1'b0, 5'h00, 3'b111);
      #2;
      checks++; if (bus.addr1_data !== addrTab[0]) begin errors++; $display("[TB] FAIL stall_hold %0d got %h exp %h", k, bus.addr1_data, addrTab[0]); end
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL stall_ready %0d got %b exp 000", k, bus.req_ready); end
    end
    @(negedge clk);
    setInputs(3'b100, 1'b1, 1'b0, 5'h00, 3'b111);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      setInputs(3'b000, 1'b1, 1'b1, 5'h0B, 3'b011);
      #2;
      checks++; if (bus.data1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready %0d got %b exp 0", k, bus.data1_ready); end
      checks++; if (bus.rsp_valid !== 3'b100) begin errors++; $display("[TB] FAIL bp_rsp %0d got %b exp 100", k, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 5'h0B) begin errors++; $display("[TB] FAIL bp_data %0d got %h exp 0B", k, bus.rsp_data); end
    end
    @(negedge clk);
    setInputs(3'b000, 1'b1, 1'b1, 5'h0B, 3'b111);
    #2;
    checks++; if (bus.data1_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b exp 1", bus.data1_ready); end
    @(negedge clk);
    setInputs(3'b000, 1'b1, 1'b0, 5'h00, 3'b000);
    #2;
    checks++; if (bus.data1_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_empty_after got %b exp 1", bus.data1_ready); end
  endtask

  task automatic test_orphan();
    logic expErr;
`ifdef RECT_ARB_CHECK_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    doReset();
    @(negedge clk);
    setInputs(3'b000, 1'b0, 1'b1, 5'h1F, 3'b000);
    #2;
    checks++; if (bus.data1_ready !== 1'b1) begin errors++; $display("[TB] FAIL orphan_drain got %b exp 1", bus.data1_ready); end
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL orphan_rsp got %b exp 000", bus.rsp_valid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      setInputs(3'b000, 1'b0, 1'b0, 5'h00, 3'b000);
      #2;
      checks++; if (errOrphan !== expErr) begin errors++; $display("[TB] FAIL orphan_sticky %0d got %b exp %b", k, errOrphan, expErr); end
    end
    doReset();
    #2;
    checks++; if (errOrphan !== 1'b0) begin errors++; $display("[TB] FAIL orphan_clear got %b exp 0", errOrphan); end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setInputs(3'b111, 1'b1, 1'b0, 5'h00, 3'b000);
    end
    @(negedge clk);
    setInputs(3'b000, 1'b0, 1'b0, 5'h00, 3'b000);
    #2;
    checks++; if (bus.data1_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_outstanding got %b exp 0", bus.data1_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++; if (bus.data1_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_flushed got %b exp 1", bus.data1_ready); end
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL mid_rsp got %b exp 000", bus.rsp_valid); end
    @(negedge clk);
    setInputs(3'b111, 1'b1, 1'b0, 5'h00, 3'b000);
    #2;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL mid_first_winner got %b exp 001", bus.req_ready); end
  endtask

  initial begin
    addrTab[0] = 14'h0100;
    addrTab[1] = 14'h0200;
    addrTab[2] = 14'h0300;
    setInputs(3'b000, 1'b0, 1'b0, 5'h00, 3'b000);
    bus.req_addr = '0;
    test_reset();
    test_round_robin();
    test_routing();
    test_full();
    test_back_to_back();
    test_orphan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
